// File: rtl/multicycle_control_fsm.sv
// Main control unit for the multi-cycle 16-bit TSC CPU.
// Each instruction is sequenced through IF/ID/EX/MEM/WB. The block stalls on the
// memory ready handshake, drives the datapath mux and enable strobes, produces
// the 4-bit ALUOp, counts retired instructions and flags HLT.
//
// Ports:
//   clk, reset           rising-edge clock; synchronous active-high reset
//   opcode, funct        IR[15:12] and IR[5:0] of the current instruction
//   mem_ready            memory finished the current read or write this cycle
//   branch_taken         datapath comparator result for the current branch
//   alu_op               ALUOp sent to the ALU control decoder
//   alu_src_a/_b         ALU operand selects
//   pc_write(_cond)      unconditional / branch-qualified PC load
//   pc_source            PC next-value select
//   i_or_d               memory address select (instruction or data)
//   mem_read/mem_write   memory requests
//   ir_write             IR latch enable
//   reg_write/reg_dst    register file write enable and destination select
//   wb_sel               register write-back data select
//   output_en            WWD output strobe
//   is_halted            HLT has been reached
//   num_inst             retired instruction count
module multicycle_control_fsm #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic [3:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             output_en,
    output logic             is_halted,
    output logic [CNT_W-1:0] num_inst
);

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    localparam logic [3:0] ALUOP_ADD   = 4'd4;
    localparam logic [3:0] ALUOP_RTYPE = 4'd15;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_inst_q;
    logic               is_halted_q;

    logic is_rtype, r_alu, r_jpr, r_jrl, r_wwd, r_hlt, r_valid;
    logic retire;

    // Instruction class decode from the IR fields
    always_comb begin
        is_rtype = (opcode == OP_RTYPE);
        r_alu    = is_rtype && (funct[5:3] == 3'd0);
        r_jpr    = is_rtype && (funct == FN_JPR);
        r_jrl    = is_rtype && (funct == FN_JRL);
        r_wwd    = is_rtype && (funct == FN_WWD);
        r_hlt    = is_rtype && (funct == FN_HLT);
        r_valid  = r_alu || r_jpr || r_jrl || r_wwd || r_hlt;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                if (r_hlt)                     state_d = S_HALT;
                else if (is_rtype && !r_valid) state_d = S_IF;  // undefined funct retires as NOP
                else                           state_d = S_EX;
            end
            S_EX: begin
                if (is_rtype) begin
                    state_d = r_alu ? S_WB : S_IF;
                end else begin
                    case (opcode)
                        OP_ADI, OP_ORI, OP_LHI: state_d = S_WB;
                        OP_LWD, OP_SWD:         state_d = S_MEM;
                        default:                state_d = S_IF;
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ready) state_d = (opcode == OP_LWD) ? S_WB : S_IF;
            end
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // An instruction retires on any edge from a non-IF state back into IF
    assign retire = (state_q != S_IF) && (state_d == S_IF);

    // State, retired counter and halt flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IF;
            num_inst_q  <= '0;
            is_halted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) num_inst_q <= num_inst_q + CNT_W'(1);
            if (state_d == S_HALT) is_halted_q <= 1'b1;
        end
    end

    // Datapath control decode from the current state and IR fields
    always_comb begin
        alu_op        = 4'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        wb_sel        = 2'b00;
        output_en     = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
            end
            S_ID: begin
                alu_op    = ALUOP_ADD;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
            end
            S_EX: begin
                if (is_rtype) begin
                    if (r_alu || r_wwd) begin
                        alu_op    = ALUOP_RTYPE;
                        alu_src_a = 1'b1;
                    end
                    output_en = r_wwd;
                    if (r_jpr || r_jrl) begin
                        pc_write  = 1'b1;
                        pc_source = 2'b11;
                    end
                    if (r_jrl) begin
                        reg_write = 1'b1;
                        reg_dst   = 2'b10;
                        wb_sel    = 2'b10;
                    end
                end else begin
                    case (opcode)
                        OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
                            alu_op        = opcode;
                            alu_src_a     = 1'b1;
                            pc_source     = 2'b01;
                            pc_write_cond = branch_taken;
                        end
                        OP_ADI, OP_ORI, OP_LHI, OP_LWD, OP_SWD: begin
                            alu_op    = opcode;
                            alu_src_a = 1'b1;
                            alu_src_b = 2'b10;
                        end
                        OP_JMP: begin
                            pc_write  = 1'b1;
                            pc_source = 2'b10;
                        end
                        OP_JAL: begin
                            pc_write  = 1'b1;
                            pc_source = 2'b10;
                            reg_write = 1'b1;
                            reg_dst   = 2'b10;
                            wb_sel    = 2'b10;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (opcode == OP_LWD);
                mem_write = (opcode == OP_SWD);
            end
            S_WB: begin
                reg_write = 1'b1;
                if (is_rtype) begin
                    reg_dst = 2'b01;
                end else if (opcode == OP_LWD) begin
                    wb_sel = 2'b01;
                end
            end
            default: ;
        endcase
        // No side-effecting strobe may leave the block while reset is held
        if (reset) begin
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
            output_en     = 1'b0;
        end
    end

    assign is_halted = is_halted_q;
    assign num_inst  = num_inst_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: each stimulus cycle pushes its
// hand-computed expected control word into a scoreboard queue; a monitor pops
// and compares on the falling edge.
module tb_multicycle_control_fsm;

    logic        clk;
    logic        reset;
    logic [3:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        branch_taken;
    logic [3:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_sel;
    logic        output_en;
    logic        is_halted;
    logic [15:0] num_inst;

    multicycle_control_fsm #(.CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .branch_taken  (branch_taken),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .wb_sel        (wb_sel),
        .output_en     (output_en),
        .is_halted     (is_halted),
        .num_inst      (num_inst)
    );

    typedef struct {
        logic [21:0] ctl;
        logic [15:0] ni;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    logic [21:0] e_ifw, e_ifr, e_id, e_zero;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Control word layout: alu_op, src_a, src_b, pc_write, pc_write_cond, pc_source,
    // i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, wb_sel, output_en, is_halted
    function automatic logic [21:0] v(int aop, int sa, int sbv, int pcw, int pcwc, int pcs,
                                      int iord, int mr, int mw, int irw, int rw, int rd,
                                      int wbs, int oe, int h);
        return {4'(aop), 1'(sa), 2'(sbv), 1'(pcw), 1'(pcwc), 2'(pcs), 1'(iord), 1'(mr),
                1'(mw), 1'(irw), 1'(rw), 2'(rd), 2'(wbs), 1'(oe), 1'(h)};
    endfunction

    task automatic step(input logic rst, input logic [3:0] op, input logic [5:0] fn,
                        input logic mrdy, input logic bt, input logic [21:0] e,
                        input logic [15:0] eni, input string nm);
        exp_t it;
        reset        = rst;
        opcode       = op;
        funct        = fn;
        mem_ready    = mrdy;
        branch_taken = bt;
        it.ctl  = e;
        it.ni   = eni;
        it.name = nm;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT output against the oldest expectation mid-cycle
    initial begin
        exp_t        it;
        logic [21:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it  = sb.pop_front();
                act = {alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source,
                       i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, wb_sel,
                       output_en, is_halted};
                checks++;
                if (act === it.ctl && num_inst === it.ni)
                    passed++;
                else
                    $display("FAIL %s: got ctl=%06h num_inst=%0d, want ctl=%06h num_inst=%0d",
                             it.name, act, num_inst, it.ctl, it.ni);
            end
        end
    end

    initial begin
        e_zero = '0;
        e_ifw  = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        e_ifr  = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        e_id   = v(4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Power-up reset; first cycle state is unknown, so it is not checked
        reset = 1'b1; opcode = 4'd0; funct = 6'd0; mem_ready = 1'b0; branch_taken = 1'b0;
        @(posedge clk); #1;
        step(1, 15, 0, 1, 0, e_zero, 0, "reset_idle");

        // ADD: IF, ID, EX, WB
        step(0, 15, 0, 1, 0, e_ifr, 0, "add_if");
        step(0, 15, 0, 1, 0, e_id, 0, "add_id");
        step(0, 15, 0, 1, 0, v(15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, "add_ex");
        step(0, 15, 0, 1, 0, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 0, "add_wb");

        // LWD with 2 IF stall cycles and 3 MEM stall cycles (10 cycles total)
        step(0, 7, 0, 0, 0, e_ifw, 1, "lwd_if_stall0");
        step(0, 7, 0, 0, 0, e_ifw, 1, "lwd_if_stall1");
        step(0, 7, 0, 1, 0, e_ifr, 1, "lwd_if_ready");
        step(0, 7, 0, 0, 0, e_id, 1, "lwd_id");
        step(0, 7, 0, 1, 0, v(7, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, "lwd_ex");
        step(0, 7, 0, 0, 0, v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1, "lwd_mem_stall0");
        step(0, 7, 0, 0, 0, v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1, "lwd_mem_stall1");
        step(0, 7, 0, 0, 0, v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1, "lwd_mem_stall2");
        step(0, 7, 0, 1, 0, v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1, "lwd_mem_ready");
        step(0, 7, 0, 1, 0, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), 1, "lwd_wb");

        // BEQ taken (branch_taken also high in ID, where it must be ignored)
        step(0, 1, 0, 1, 1, e_ifr, 2, "beq_t_if");
        step(0, 1, 0, 1, 1, e_id, 2, "beq_t_id");
        step(0, 1, 0, 1, 1, v(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2, "beq_t_ex");
        // BEQ not taken
        step(0, 1, 0, 1, 0, e_ifr, 3, "beq_n_if");
        step(0, 1, 0, 1, 0, e_id, 3, "beq_n_id");
        step(0, 1, 0, 1, 0, v(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 3, "beq_n_ex");

        // JAL
        step(0, 10, 0, 1, 0, e_ifr, 4, "jal_if");
        step(0, 10, 0, 1, 0, e_id, 4, "jal_id");
        step(0, 10, 0, 1, 0, v(0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 1, 2, 2, 0, 0), 4, "jal_ex");

        // ORI (I-type write-back to rt)
        step(0, 5, 0, 1, 0, e_ifr, 5, "ori_if");
        step(0, 5, 0, 1, 0, e_id, 5, "ori_id");
        step(0, 5, 0, 1, 0, v(5, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 5, "ori_ex");
        step(0, 5, 0, 1, 0, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 5, "ori_wb");

        // Undefined R-type funct retires as a NOP straight from ID
        step(0, 15, 10, 1, 0, e_ifr, 6, "nop_if");
        step(0, 15, 10, 1, 0, e_id, 6, "nop_id");

        // WWD: output_en for exactly the EX cycle
        step(0, 15, 28, 1, 0, e_ifr, 7, "wwd_if");
        step(0, 15, 28, 1, 0, e_id, 7, "wwd_id");
        step(0, 15, 28, 1, 0, v(15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 7, "wwd_ex");

        // HLT: halts after ID, does not retire, ignores memory activity
        step(0, 15, 29, 1, 0, e_ifr, 8, "hlt_if");
        step(0, 15, 29, 1, 0, e_id, 8, "hlt_id");
        for (int i = 0; i < 20; i++)
            step(0, 15, 29, 1, 1, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 8, "halt_hold");

        // Reset out of HALT
        step(1, 15, 29, 1, 0, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 8, "halt_reset");
        step(0, 15, 25, 1, 0, e_ifr, 0, "after_halt_if");

        // JPR retires so the counter is non-zero before the SWD reset test
        step(0, 15, 25, 1, 0, e_id, 0, "jpr_id");
        step(0, 15, 25, 1, 0, v(0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, "jpr_ex");

        // SWD interrupted by reset during its MEM stall
        step(0, 8, 0, 1, 0, e_ifr, 1, "swd_if");
        step(0, 8, 0, 1, 0, e_id, 1, "swd_id");
        step(0, 8, 0, 0, 0, v(8, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, "swd_ex");
        step(0, 8, 0, 0, 0, v(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 1, "swd_mem_stall0");
        step(0, 8, 0, 0, 0, v(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 1, "swd_mem_stall1");
        step(1, 8, 0, 0, 0, v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1, "swd_reset");
        step(0, 8, 0, 1, 0, e_ifr, 0, "swd_after_reset_if");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle CPU main control unit for the 16-bit TSC ISA.
- Sequences each instruction through IF/ID/EX/MEM/WB and stalls on the memory ready handshake.
- Drives the datapath mux/enable strobes and produces the 4-bit ALUOp consumed by the ALU control decoder, i.e. the producing end of the ALUOp/funct interface.
- Also counts retired instructions and flags halt.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  4  IR[15:12]
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completed current read/write this cycle
- branch_taken  in  1  datapath comparator result for the current branch opcode
- alu_op  out  4  ALUOp to ALU control
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 1, 10=sign/zero-ext imm
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by branch_taken (gated inside this block)
- pc_source  out  2  00=ALU result, 01=branch target, 10=jump target, 11=rs
- i_or_d  out  1  0=instruction address, 1=data address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  latch IR
- reg_write  out  1  register file write
- reg_dst  out  2  00=rt, 01=rd, 10=$2
- wb_sel  out  2  00=ALU out, 01=MDR, 10=PC
- output_en  out  1  WWD output strobe
- is_halted  out  1  HLT reached
- num_inst  out  CNT_W  retired instruction count

Behaviour:
- Encodings:
  - Opcodes: BNE=0, BEQ=1, BGZ=2, BLZ=3, ADI=4, ORI=5, LHI=6, LWD=7, SWD=8, JMP=9, JAL=10, RTYPE=15.
  - Funct: ADD..SHR=0..7, JPR=25, JRL=26, WWD=28, HLT=29.
- States: IF, ID, EX, MEM, WB, HALT. Outputs are Moore-decoded from state plus opcode/funct. All outputs not listed for a state are 0.
- Reset:
  - State=IF, num_inst=0, is_halted=0.
  - Reset wins over everything, including HALT and mid-stall.
  - In the reset cycle, mem_read/mem_write/ir_write/pc_write/reg_write/output_en are forced to 0.
- IF:
  - mem_read=1, i_or_d=0.
  - ir_write=mem_ready.
  - Holds while mem_ready=0; goes to ID when mem_ready=1.
- ID:
  - alu_src_a=0, alu_src_b=01, alu_op=4 (ADD), pc_write=1, pc_source=00 (PC<=PC+1).
  - Next state:
    - HLT: HALT.
    - RTYPE with undefined funct: IF, retires as NOP.
    - All others: EX.
- EX:
  - RTYPE ALU (funct 0-7): alu_op=15, alu_src_a=1, alu_src_b=00; go to WB.
  - ADI/ORI/LHI: alu_op=opcode, alu_src_a=1, alu_src_b=10; go to WB.
  - LWD/SWD: alu_op=opcode, alu_src_a=1, alu_src_b=10; go to MEM.
  - Branches:
    - alu_op=opcode, alu_src_a=1, alu_src_b=00.
    - pc_source=01, pc_write_cond=branch_taken.
    - Go to IF (retire).
  - JMP: pc_write=1, pc_source=10; go to IF.
  - JAL: JMP actions plus reg_write=1, reg_dst=10, wb_sel=10. PC still holds PC+1 during this cycle. Go to IF.
  - JPR: pc_write=1, pc_source=11; go to IF.
  - JRL: JPR actions plus JAL link write; go to IF.
  - WWD: alu_op=15, alu_src_a=1, output_en=1 for exactly this cycle; go to IF.
- MEM:
  - i_or_d=1; mem_read=1 (LWD) or mem_write=1 (SWD).
  - Holds, with strobe asserted, until mem_ready.
  - On ready, LWD goes to WB and SWD goes to IF.
- WB:
  - reg_write=1.
  - R-type: reg_dst=01, wb_sel=00.
  - I-type: reg_dst=00, wb_sel=00.
  - LWD: reg_dst=00, wb_sel=01.
  - Go to IF.
- num_inst:
  - Increments by 1 on each edge leaving the final state of an instruction into IF, including NOP.
  - Wraps modulo 2^CNT_W.
  - Does not increment on HLT entry or while in HALT.
- HALT:
  - is_halted=1, all strobes 0.
  - Remains until reset.
- Stall: mem_ready ignored outside IF/MEM. ir_write is never asserted without mem_ready.
- Latency without stalls:
  - 3 cycles: branch, J*, WWD.
  - 4 cycles: R/I ALU, SWD.
  - 5 cycles: LWD.

Test Plan:
- Reset, then ADD (opcode 15, funct 0) with mem_ready=1:
  - State sequence IF,ID,EX,WB.
  - WB has reg_write=1, reg_dst=01.
  - num_inst=1 after 4 cycles.
- LWD with mem_ready low 2 cycles in IF and 3 cycles in MEM:
  - mem_read held throughout.
  - ir_write only on the ready cycle.
  - wb_sel=01 in WB.
  - Total 10 cycles, num_inst increments once.
- BEQ with branch_taken=1:
  - EX asserts pc_write_cond=1, pc_source=01.
  - Repeat with branch_taken=0: pc_write_cond=0.
  - Both retire in 3 cycles.
- JAL:
  - EX asserts pc_write=1, pc_source=10, reg_write=1, reg_dst=10, wb_sel=10 in one cycle.
- WWD then HLT:
  - output_en pulses for exactly 1 cycle.
  - After HLT's ID, is_halted=1 and stays 1 for 20 cycles with no strobes.
  - num_inst is not incremented by HLT.
  - reset returns to IF with is_halted=0 and num_inst=0.
- Reset asserted mid-MEM stall of SWD:
  - Next cycle state=IF and mem_write=0 during reset.
  - num_inst=0.
